// File: rtl/fft_frame_loader.sv
// ============================================================================
// fft_frame_loader
// ----------------------------------------------------------------------------
// Front end for FSM_butterfly / FFT_stage_unit.  Complex samples arrive one
// at a time over a valid/ready stream and are written straight into the
// parallel frame buses in bit-reversed order.  That way the butterfly stages
// can consume the frame in natural order.  When a frame is complete the
// loader emits the enable / end_f start sequence.  It then holds the frame
// stable until the butterfly reports completion on right_data_f.
//
// Parameters
//   N_POINTS : samples per frame (power of two)
//   LOG2N    : log2(N_POINTS), width of the sample / slot index
//   DATA_W   : two's-complement sample width
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous, active-low reset
//   s_valid      in   input sample valid
//   s_ready      out  loader accepts a sample (FILL state only)
//   s_real       in   sample real part
//   s_imag       in   sample imaginary part
//   s_last       in   final sample of a frame
//   frame_real   out  packed real frame, slot k at [k*DATA_W +: DATA_W]
//   frame_imag   out  packed imaginary frame, same layout
//   enable       out  one-cycle start pulse to FSM_butterfly
//   end_f        out  one-cycle load-complete pulse to FSM_butterfly
//   right_data_f in   completion flag from FSM_butterfly (WAIT only)
//   busy         out  high in every state except FILL
//   err_align    out  one-cycle pulse when s_last arrives early
// ============================================================================
module fft_frame_loader #(
   parameter int N_POINTS = 32,
   parameter int LOG2N    = 5,
   parameter int DATA_W   = 10
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [DATA_W-1:0]            s_real,
   input  logic [DATA_W-1:0]            s_imag,
   input  logic                         s_last,
   output logic [N_POINTS*DATA_W-1:0]   frame_real,
   output logic [N_POINTS*DATA_W-1:0]   frame_imag,
   output logic                         enable,
   output logic                         end_f,
   input  logic                         right_data_f,
   output logic                         busy,
   output logic                         err_align
);

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_END   = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

   state_t             state;
   state_t             next_state;
   logic [LOG2N-1:0]   n;
   logic [LOG2N-1:0]   slot;
   logic               accept;
   logic               last_index;
   logic               early_last;

   // Reverse the bit order of a sample index to obtain its frame slot.
   function automatic logic [LOG2N-1:0] bit_reverse(input logic [LOG2N-1:0] idx);
      logic [LOG2N-1:0] r;
      r = '0;
      for (int b = 0; b < LOG2N; b++) begin
         r[b] = idx[LOG2N-1-b];
      end
      return r;
   endfunction

   // Handshake and framing decode.  s_ready is a pure decode of the state
   // register, so s_valid is automatically ignored outside FILL.
   assign s_ready    = (state == ST_FILL);
   assign busy       = (state != ST_FILL);
   assign accept     = s_valid && s_ready;
   assign last_index = (n == LOG2N'(N_POINTS - 1));
   assign early_last = accept && s_last && !last_index;
   assign slot       = bit_reverse(n);

   // Next-state logic.  A frame is only issued once the full count of samples
   // has been accepted; an early s_last restarts the count without issuing.
   // right_data_f only matters while waiting for the butterfly.
   always_comb begin
      next_state = state;
      case (state)
         ST_FILL: begin
            if (accept && last_index) begin
               next_state = ST_ISSUE;
            end
         end
         ST_ISSUE: next_state = ST_END;
         ST_END:   next_state = ST_WAIT;
         ST_WAIT: begin
            if (right_data_f) begin
               next_state = ST_FILL;
            end
         end
         default:  next_state = ST_FILL;
      endcase
   end

   // State register, sample counter and registered pulse outputs.  The
   // pulses are derived from next_state, so each one lines up exactly with
   // the cycle its state is occupied.  The three pulses belong to distinct
   // states or to FILL, so they can never overlap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_FILL;
         n         <= '0;
         enable    <= 1'b0;
         end_f     <= 1'b0;
         err_align <= 1'b0;
      end else begin
         state     <= next_state;
         enable    <= (next_state == ST_ISSUE);
         end_f     <= (next_state == ST_END);
         err_align <= early_last;
         if (accept) begin
            if (last_index || s_last) begin
               n <= '0;
            end else begin
               n <= n + 1'b1;
            end
         end
      end
   end

   // Frame storage.  Slots are written only on an accepted sample, so the
   // buses hold still from ISSUE through WAIT.  Slots are never bulk-cleared
   // between frames; an aborted frame leaves stale data behind that is
   // simply overwritten by the next frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_real <= '0;
         frame_imag <= '0;
      end else if (accept) begin
         frame_real[int'(slot)*DATA_W +: DATA_W] <= s_real;
         frame_imag[int'(slot)*DATA_W +: DATA_W] <= s_imag;
      end
   end

endmodule

// File: doc/fft_frame_loader.md
# fft_frame_loader

Front-end initiator for `FSM_butterfly` / `FFT_stage_unit`. Accepts complex samples one at a time over a valid/ready stream and packs them, in bit-reversed order, into the 320-bit parallel `in_real`/`in_imag` frame buses. It then drives the `enable`/`end_f` start sequence into `FSM_butterfly`, and holds the frame stable until `right_data_f` confirms completion. It is the source end of the protocol that `FSM_butterfly` responds to.

## Interface
- `N_POINTS`, 32: samples per frame; must be a power of 2.
- `LOG2N`, 5: log2(`N_POINTS`); sets the slot index width.
- `DATA_W`, 10: sample width, two's complement, matching the stage-unit fixed-point format.
- `clk`  in  1  Single clock; all state changes on the rising edge.
- `rst`  in  1  Asynchronous, active-low reset.
- `s_valid`  in  1  Input sample valid.
- `s_ready`  out  1  Loader can accept a sample.
- `s_real`  in  `DATA_W`  Sample real part.
- `s_imag`  in  `DATA_W`  Sample imaginary part.
- `s_last`  in  1  Marks the final sample of a frame.
- `frame_real`  out  `N_POINTS*DATA_W`  Packed real frame; connects to `in_real`.
- `frame_imag`  out  `N_POINTS*DATA_W`  Packed imaginary frame; connects to `in_imag`.
- `enable`  out  1  Start pulse to `FSM_butterfly`.
- `end_f`  out  1  Load-complete pulse to `FSM_butterfly`.
- `right_data_f`  in  1  Completion flag from `FSM_butterfly`.
- `busy`  out  1  High in all states except FILL.
- `err_align`  out  1  One-cycle pulse on a framing error.

## Operation
- **Packing**
  - Sample index n (0..`N_POINTS`-1) is counted from the start of the frame.
  - Sample n is written to slot k = bitrev(n), over `LOG2N` bits.
  - Slot k occupies bits [k*`DATA_W`+`DATA_W`-1 : k*`DATA_W`] of each bus.
  - Samples are stored unmodified; no scaling or sign extension.
- **State machine**
  - FILL: `s_ready`=1. Each handshake (`s_valid`&&`s_ready`) writes one slot and increments n.
  - FILL → ISSUE: on accepting sample n=`N_POINTS`-1, counter wraps to 0.
  - ISSUE: `enable`=1 for exactly one cycle; next state is END.
  - END: `end_f`=1 for exactly one cycle; next state is WAIT.
  - WAIT: stays until `right_data_f` is sampled high, then goes to FILL.
- **Framing**
  - `s_last` accepted with n<`N_POINTS`-1: `err_align` pulses the next cycle, n resets to 0, and the partial frame is discarded (no ISSUE). Slots already written keep stale data until overwritten.
  - `s_last` low on sample `N_POINTS`-1: the frame still completes with no error.
  - `s_last` high on sample `N_POINTS`-1: normal completion.
- **Protocol**
  - `right_data_f` is ignored in FILL, ISSUE and END.
  - `s_valid` is ignored whenever `s_ready`=0.
- **Frame buses**
  - Unchanged from ISSUE through the last WAIT cycle.
  - Not cleared between frames; slots are overwritten individually during FILL.

## Timing
- **Reset values** (asynchronous assert; release synchronous to `clk`): state FILL, n=0, `s_ready`=1.
  - All other outputs reset to 0: `frame_real`, `frame_imag`, `enable`, `end_f`, `busy`, `err_align`.
- **Reset in any state**: frame in progress is aborted; no `enable`/`end_f` is emitted afterwards for it.
- **Cycle timing, with the last sample accepted at edge T**:
  - `enable`=1 in cycle T+1.
  - `end_f`=1 in cycle T+2.
  - WAIT begins at T+3.
- **Return to FILL**: `right_data_f` sampled high at edge W gives `s_ready`=1 from cycle W+1.
- **Throughput**: minimum frame period is `N_POINTS`+3 cycles (35 for defaults) with continuous `s_valid` and `right_data_f` tied high.
- **Output style**: `enable`, `end_f` and `err_align` are registered, glitch-free, and never asserted together.

## Test plan
- **Reset values**: apply `rst`=0 mid-stream.
  - All outputs match the reset values above.
  - `s_ready`=1 one cycle after `rst`=1.
- **Bit-reversed packing**: stream n=0..31 with real=n, imag=31-n, `s_last` on n=31.
  - At the `enable` cycle, slot0 real=0, slot1 real=16, slot2 real=8, slot31 real=31, slot1 imag=15.
  - `enable` high exactly 1 cycle, at the first cycle after the 32nd handshake.
- **Handshake gaps and completion**: random `s_valid` gaps; `right_data_f` pulsed 4 cycles after `end_f`.
  - Buses stay stable throughout WAIT and `s_ready`=0 throughout WAIT.
  - `s_ready` returns 1 the cycle after the pulse.
- **Early `s_last`**: assert `s_last` on n=9.
  - `err_align` pulses once.
  - No `enable`.
  - The next sample lands in slot 0, and a following full frame issues normally.
- **Reset during WAIT**: assert `rst` during WAIT.
  - Buses go to 0 and `busy`=0.
  - No `end_f`/`enable` follows until a new 32-sample frame is loaded.
- **`right_data_f` tied high**:
  - Frame period is 35 cycles.
  - Exactly one `enable` and one `end_f` per frame.
